// File: rtl/bnn_frame_if.sv
// bnn_frame_if: host byte stream, core handshake and status bundle for bnn_frame_controller
interface bnn_frame_if #(
  parameter int IMG_PIXELS = 784,
  parameter int PACKED     = 1,
  parameter int RESULT_W   = 8
);
  localparam int RX_BYTES = PACKED ? (IMG_PIXELS + 7) / 8 : IMG_PIXELS;
  localparam int CNT_W    = $clog2(RX_BYTES + 1);
  logic                  frame_active;
  logic                  soft_clear;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic [IMG_PIXELS-1:0] img_bits;
  logic                  core_start;
  logic                  core_done;
  logic [RESULT_W-1:0]   core_result;
  logic                  busy;
  logic [1:0]            err_code;
  logic [2:0]            dbg_state;
  logic [CNT_W-1:0]      dbg_rx_count;
  modport master (
    output frame_active, soft_clear, rx_valid, rx_data, tx_ready, core_done, core_result,
    input  rx_ready, tx_valid, tx_data, img_bits, core_start, busy, err_code, dbg_state, dbg_rx_count
  );
  modport slave (
    input  frame_active, soft_clear, rx_valid, rx_data, tx_ready, core_done, core_result,
    output rx_ready, tx_valid, tx_data, img_bits, core_start, busy, err_code, dbg_state, dbg_rx_count
  );
endinterface

// File: rtl/bnn_frame_controller.sv
// bnn_frame_controller: unpacks a host frame into the BNN image, runs the core, streams the result back; BNN_FRAME_CHECKSUM_EN adds a trailing XOR check byte
module bnn_frame_controller #(
  parameter int IMG_PIXELS  = 784,
  parameter int PACKED      = 1,
  parameter int RESULT_W    = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic      clk,
  input logic      rst,
  bnn_frame_if.slave bus
);
  localparam int RX_BYTES  = PACKED ? (IMG_PIXELS + 7) / 8 : IMG_PIXELS;
  localparam int RES_BYTES = (RESULT_W + 7) / 8;
  localparam int RES_W     = RES_BYTES * 8;
  localparam int CNT_W     = $clog2(RX_BYTES + 1);
  localparam int TX_W      = RES_BYTES > 1 ? $clog2(RES_BYTES) : 1;
  localparam int TO_W      = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RX    = 3'd1,
`ifdef BNN_FRAME_CHECKSUM_EN
    S_CHK   = 3'd2,
`endif
    S_INFER = 3'd3,
    S_TX    = 3'd4,
    S_DRAIN = 3'd5,
    S_CLEAR = 3'd6
  } state_t;
  state_t                r_state, w_next;
  logic                  r_fa_q;
  logic [IMG_PIXELS-1:0] r_img;
  logic [CNT_W-1:0]      r_rx_cnt;
  logic [1:0]            r_err, w_err;
  logic [RES_W-1:0]      r_res, w_tx_shift;
  logic [TX_W-1:0]       r_tx_idx;
  logic [TO_W-1:0]       r_wait;
  logic                  r_core_start;
  logic                  w_frame_start, w_rx_acc, w_rx_last, w_tx_acc, w_tx_last, w_timeout, w_start;
`ifdef BNN_FRAME_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif
  assign w_frame_start = bus.frame_active && !r_fa_q;
  assign w_rx_acc      = (r_state == S_RX) && bus.rx_valid && bus.frame_active;
  assign w_rx_last     = r_rx_cnt == CNT_W'(RX_BYTES - 1);
  assign w_tx_acc      = (r_state == S_TX) && bus.tx_ready && bus.frame_active;
  assign w_tx_last     = r_tx_idx == TX_W'(RES_BYTES - 1);
  assign w_timeout     = (TIMEOUT_CYC > 0) && (r_wait == TO_W'(TIMEOUT_CYC - 1));
  assign w_start       = (r_state == S_IDLE) && (w_next == S_RX);
  assign w_tx_shift    = r_res >> {r_tx_idx, 3'b000};
`ifdef BNN_FRAME_CHECKSUM_EN
  assign bus.rx_ready  = bus.frame_active && ((r_state == S_RX) || (r_state == S_CHK));
`else
  assign bus.rx_ready  = bus.frame_active && (r_state == S_RX);
`endif
  assign bus.tx_valid     = r_state == S_TX;
  assign bus.tx_data      = w_tx_shift[7:0];
  assign bus.img_bits     = r_img;
  assign bus.core_start   = r_core_start;
  assign bus.busy         = r_state != S_IDLE;
  assign bus.err_code     = r_err;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_rx_count = r_rx_cnt;
  // next state and error code; soft_clear overrides every transition
  always_comb begin
    w_next = r_state;
    w_err  = r_err;
    if (bus.soft_clear)
      w_next = (r_state == S_IDLE) ? S_IDLE : S_CLEAR;
    else
      case (r_state)
        S_IDLE: if (w_frame_start) begin
          w_next = S_RX;
          w_err  = 2'b00;
        end
        S_RX: if (!bus.frame_active) begin
          w_next = S_CLEAR;
          w_err  = 2'b01;
        end else if (w_rx_acc && w_rx_last) begin
`ifdef BNN_FRAME_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_INFER;
`endif
        end
`ifdef BNN_FRAME_CHECKSUM_EN
        S_CHK: if (!bus.frame_active) begin
          w_next = S_CLEAR;
          w_err  = 2'b01;
        end else if (bus.rx_valid) begin
          w_next = (bus.rx_data == r_xor) ? S_INFER : S_CLEAR;
          w_err  = (bus.rx_data == r_xor) ? r_err : 2'b11;
        end
`endif
        S_INFER: if (bus.core_done)
          w_next = S_TX;
        else if (w_timeout) begin
          w_next = S_CLEAR;
          w_err  = 2'b10;
        end
        S_TX:    w_next = !bus.frame_active ? S_CLEAR : (w_tx_acc && w_tx_last) ? S_DRAIN : S_TX;
        S_DRAIN: w_next = bus.frame_active ? S_DRAIN : S_CLEAR;
        default: w_next = S_IDLE;
      endcase
  end
  // state, status and the one-cycle start pulse on entry to INFER
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_err        <= 2'b00;
      r_fa_q       <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_err        <= w_err;
      r_fa_q       <= bus.frame_active;
      r_core_start <= (w_next == S_INFER) && (r_state != S_INFER);
    end
  end
  // receive side: byte counter doubles as the pixel pointer, pixels past the image are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt <= '0;
      r_img    <= '0;
    end else if ((r_state == S_CLEAR) || ((r_state == S_IDLE) && bus.soft_clear)) begin
      r_rx_cnt <= '0;
      r_img    <= '0;
    end else begin
      r_rx_cnt <= w_start ? '0 : w_rx_acc ? r_rx_cnt + 1'b1 : r_rx_cnt;
      for (int i = 0; i < IMG_PIXELS; i++)
        if (w_rx_acc && (r_rx_cnt == CNT_W'(PACKED ? i / 8 : i)))
          r_img[i] <= PACKED ? bus.rx_data[3'(i % 8)] : bus.rx_data[0];
    end
  end
`ifdef BNN_FRAME_CHECKSUM_EN
  // running XOR of the image bytes of the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_xor <= 8'h00;
    else
      r_xor <= w_start ? 8'h00 : w_rx_acc ? r_xor ^ bus.rx_data : r_xor;
  end
`endif
  // inference wait counter, result latch and transmit byte index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait   <= '0;
      r_res    <= '0;
      r_tx_idx <= '0;
    end else begin
      r_wait   <= (r_state == S_INFER) ? r_wait + 1'b1 : '0;
      r_res    <= ((r_state == S_INFER) && (w_next == S_TX)) ? RES_W'(bus.core_result) : r_res;
      r_tx_idx <= (r_state != S_TX) ? '0 : w_tx_acc ? r_tx_idx + 1'b1 : r_tx_idx;
    end
  end
endmodule
